axi4_lite_mem_slave: RTL and testbench
======================================

# axi4_lite_mem_slave

Synthesizable, parametrised AXI4-Lite memory slave that replaces the behavioural bus memory model behind `picorv32_axi` in simulation and FPGA builds. Provides byte-addressable RAM with byte strobes, independent read and write channels with programmable response latency, and error responses on out-of-range accesses. Also provides console and test-pass MMIO decoding. Sits directly on the core's `mem_axi_*` bus, one slave per core.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AXI address width.
- `MEM_BYTES`, 131072: RAM size in bytes; power of two, ≥ 4.
- `READ_LATENCY`, 0: extra cycles, 0..15, between AR handshake and `rvalid`.
- `WRITE_LATENCY`, 0: extra cycles, 0..15, between capture of both AW and W and `bvalid`.
- `CONSOLE_ADDR`, 32'h1000_0000: console MMIO address.
- `PASS_ADDR`, 32'h2000_0000: test-pass MMIO address.
- `PASS_VALUE`, 32'd123456789: value that sets `tests_passed`.
- `INIT_FILE`, "": hex image loaded with `$readmemh` if non-empty.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_axi_awvalid`/`awready` in/out 1, `mem_axi_awaddr` in ADDR_WIDTH, `mem_axi_awprot` in 3 (ignored).
- `mem_axi_wvalid`/`wready` in/out 1, `mem_axi_wdata` in 32, `mem_axi_wstrb` in 4.
- `mem_axi_bvalid` out 1, `mem_axi_bready` in 1, `mem_axi_bresp` out 2.
- `mem_axi_arvalid`/`arready` in/out 1, `mem_axi_araddr` in ADDR_WIDTH, `mem_axi_arprot` in 3 (ignored).
- `mem_axi_rvalid` out 1, `mem_axi_rready` in 1, `mem_axi_rdata` out 32, `mem_axi_rresp` out 2.
- `console_valid` out 1: one-cycle strobe on a console write.
- `console_data` out 8: `wdata[7:0]` of the last console write.
- `tests_passed` out 1: sticky pass flag.

## Operation
- Addresses are word-aligned. `addr[1:0]` is ignored. RAM index is `addr[log2(MEM_BYTES)-1:2]`.
- Address decode, in priority order:
  - `addr < MEM_BYTES`: RAM.
  - `addr == CONSOLE_ADDR`: console.
  - `addr == PASS_ADDR`: pass register.
  - Anything else: error.
- Read FSM states are IDLE, WAIT, RESP.
  - IDLE: `arready` = 1. On AR handshake, latch the address, load the counter with READ_LATENCY, and go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, sample the data, assert `rvalid`, and go to RESP.
  - RESP: hold `rvalid`, `rdata` and `rresp` stable until `rready`. Then return to IDLE.
- Write path: AW and W are captured independently. `awready` = !aw_held && state==IDLE, and `wready` likewise for W, so the two may arrive in either order or in the same cycle.
  - Once both are held, go to WAIT with WRITE_LATENCY. When the count reaches 0, commit the write, assert `bvalid`, and go to RESP.
  - RESP holds until `bready`, then clears both held flags and returns to IDLE.
- RAM write: byte lane i is written iff `wstrb[i]`. `bresp` = OKAY (2'b00).
- Console write: `console_valid` pulses 1 cycle, in the commit cycle. `console_data` = `wdata[7:0]`. RAM is untouched. `bresp` = OKAY.
- Pass write:
  - If `wdata == PASS_VALUE`, `tests_passed` is set and stays 1 until reset.
  - Any other value leaves the flag unchanged.
  - `bresp` = OKAY.
- Error access: writes have no side effect and return `bresp` = SLVERR (2'b10). Reads return `rdata` = 0 with `rresp` = SLVERR.
- MMIO reads return OKAY. The pass address reads as {31'b0, tests_passed}. The console address reads as 0.
- Read/write collision: if the read sample and the write commit to the same word fall on the same edge, the read returns the pre-write data.
- RAM contents are not affected by reset. They are initialised only from INIT_FILE.

## Timing
- Reset values: `awready`, `wready`, `arready` = 0 while `resetn` = 0. All are 1 in the first cycle after deassertion. `bvalid`, `rvalid`, `console_valid`, `tests_passed` = 0. `rdata` = 0, `console_data` = 0, `bresp`/`rresp` = 2'b00.
- Read latency: an AR handshake at edge N gives `rvalid` = 1 after edge N+1+READ_LATENCY. Minimum is 1 cycle.
- Write latency: if the later of the AW/W captures is at edge N, `bvalid` = 1 after edge N+1+WRITE_LATENCY. The RAM commit, `console_valid` and `tests_passed` update all happen on that same edge.
- Only one outstanding transaction per channel. `arready` is 0 from the handshake until R completes. `awready` is 0 while AW is held, and `wready` is 0 while W is held.
- The read and write channels are fully concurrent. Neither stalls the other.
- Asserting `resetn` low mid-transaction aborts it immediately and asynchronously. Any pending write is discarded, with no commit and no strobe.

## Test plan
- Write `0xDEADBEEF` to 0x100 with strb 4'b1111, then read 0x100: `rdata` = `0xDEADBEEF`, `rresp` = 0. Then write `0x0000AA00` with strb 4'b0010 and read: `rdata` = `0xDEADAAEF`.
- READ_LATENCY = 3, WRITE_LATENCY = 2:
  - AR handshake at edge N: `rvalid` rises after edge N+4.
  - W at edge M then AW at edge M+3: `bvalid` rises after edge M+6.
- Hold `rready`/`bready` low for 5 cycles: `rvalid`/`bvalid`, `rdata` and `resp` stay stable; `arready` stays 0; no second read is accepted.
- Read `MEM_BYTES` (0x20000): `rresp` = 2'b10, `rdata` = 0. Write there: `bresp` = 2'b10 and RAM is unchanged; reading 0x0 still returns its prior value.
- MMIO:
  - Write 0x41 to `CONSOLE_ADDR`: `console_valid` is high exactly 1 cycle with `console_data` = 0x41.
  - Write 5 to `PASS_ADDR`: `tests_passed` = 0.
  - Write 123456789 to `PASS_ADDR`: `tests_passed` = 1; a read of `PASS_ADDR` returns 1.
- Pull `resetn` low during WAIT of a write to 0x100 with data 0x12345678: `bvalid` = 0, and after reset a read of 0x100 returns the old value.

Source files
------------

// File: rtl/axi4_lite_mem_if.sv
// AXI4-Lite bus bundle between a master (the core) and the memory slave.
interface axi4_lite_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite RAM slave with byte strobes, programmable response latency,
// SLVERR on unmapped addresses, and console / test-pass MMIO registers.
module axi4_lite_mem_slave #(
  parameter int              ADDR_WIDTH    = 32,
  parameter int              MEM_BYTES     = 131072,
  parameter int              READ_LATENCY  = 0,
  parameter int              WRITE_LATENCY = 0,
  parameter logic [31:0]     CONSOLE_ADDR  = 32'h1000_0000,
  parameter logic [31:0]     PASS_ADDR     = 32'h2000_0000,
  parameter logic [31:0]     PASS_VALUE    = 32'd123456789,
  parameter string           INIT_FILE     = ""
) (
  input  logic              clk,
  input  logic              resetn,
  axi4_lite_mem_if.slave    mem_axi,
  output logic              console_valid,
  output logic [7:0]        console_data,
  output logic              tests_passed
);
  localparam int IDX_W = ($clog2(MEM_BYTES) > 2) ? $clog2(MEM_BYTES) - 2 : 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {SEL_RAM, SEL_CONSOLE, SEL_PASS, SEL_ERR} sel_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

  logic [31:0] mem [0:(1<<IDX_W)-1];

  // RAM wins over the MMIO addresses; the byte offset never takes part.
  function automatic sel_t decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] word;
    word = {a[ADDR_WIDTH-1:2], 2'b00};
    if (word < ADDR_WIDTH'(MEM_BYTES))          return SEL_RAM;
    else if (word == ADDR_WIDTH'(CONSOLE_ADDR)) return SEL_CONSOLE;
    else if (word == ADDR_WIDTH'(PASS_ADDR))    return SEL_PASS;
    else                                        return SEL_ERR;
  endfunction

  logic unused_prot;
  assign unused_prot = ^{mem_axi.awprot, mem_axi.arprot};

  rstate_t               rstate, rstate_next;
  logic [3:0]            rcnt;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic                  rsample;

  assign mem_axi.arready = resetn && (rstate == R_IDLE);
  assign mem_axi.rvalid  = (rstate == R_RESP);
  assign mem_axi.rdata   = rdata_q;
  assign mem_axi.rresp   = rresp_q;
  assign rsample         = (rstate == R_WAIT) && (rcnt == 4'd0);

  always_comb begin
    rstate_next = rstate;
    case (rstate)
      R_IDLE:  if (mem_axi.arvalid) rstate_next = R_WAIT;
      R_WAIT:  if (rcnt == 4'd0) rstate_next = R_RESP;
      R_RESP:  if (mem_axi.rready) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  // Data is sampled on the edge that raises rvalid and then frozen in RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate  <= R_IDLE;
      rcnt    <= 4'd0;
      raddr   <= '0;
      rdata_q <= 32'd0;
      rresp_q <= OKAY;
    end else begin
      rstate <= rstate_next;
      if (rstate == R_IDLE && mem_axi.arvalid) begin
        raddr <= mem_axi.araddr;
        rcnt  <= 4'(READ_LATENCY);
      end else if (rstate == R_WAIT && rcnt != 4'd0) begin
        rcnt <= rcnt - 4'd1;
      end
      if (rsample) begin
        rresp_q <= OKAY;
        case (decode(raddr))
          SEL_RAM:  rdata_q <= mem[raddr[IDX_W+1:2]];
          SEL_PASS: rdata_q <= {31'b0, tests_passed};
          SEL_CONSOLE: rdata_q <= 32'd0;
          default: begin
            rdata_q <= 32'd0;
            rresp_q <= SLVERR;
          end
        endcase
      end
    end
  end

  wstate_t               wstate, wstate_next;
  logic [3:0]            wcnt;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs, commit;
  sel_t                  wsel;

  assign mem_axi.awready = resetn && (wstate == W_IDLE) && !aw_held;
  assign mem_axi.wready  = resetn && (wstate == W_IDLE) && !w_held;
  assign mem_axi.bvalid  = (wstate == W_RESP);
  assign mem_axi.bresp   = bresp_q;
  assign aw_hs           = mem_axi.awvalid && mem_axi.awready;
  assign w_hs            = mem_axi.wvalid && mem_axi.wready;
  assign commit          = (wstate == W_WAIT) && (wcnt == 4'd0);
  assign wsel            = decode(awaddr_q);

  // Leaving IDLE on the capture edge itself keeps latency at 1+WRITE_LATENCY.
  always_comb begin
    wstate_next = wstate;
    case (wstate)
      W_IDLE:  if ((aw_held || aw_hs) && (w_held || w_hs)) wstate_next = W_WAIT;
      W_WAIT:  if (wcnt == 4'd0) wstate_next = W_RESP;
      W_RESP:  if (mem_axi.bready) wstate_next = W_IDLE;
      default: wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate        <= W_IDLE;
      wcnt          <= 4'd0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      bresp_q       <= OKAY;
      console_valid <= 1'b0;
      console_data  <= 8'd0;
      tests_passed  <= 1'b0;
    end else begin
      wstate        <= wstate_next;
      console_valid <= 1'b0;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= mem_axi.awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= mem_axi.wdata;
        wstrb_q <= mem_axi.wstrb;
      end
      if (wstate == W_IDLE && wstate_next == W_WAIT) begin
        wcnt <= 4'(WRITE_LATENCY);
      end else if (wstate == W_WAIT && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      if (commit) begin
        bresp_q <= OKAY;
        case (wsel)
          SEL_CONSOLE: begin
            console_valid <= 1'b1;
            console_data  <= wdata_q[7:0];
          end
          SEL_PASS: if (wdata_q == PASS_VALUE) tests_passed <= 1'b1;
          SEL_ERR:  bresp_q <= SLVERR;
          default:  ;
        endcase
      end
      if (wstate == W_RESP && mem_axi.bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Contents survive reset; a reset during WAIT clears commit, so nothing lands.
  always_ff @(posedge clk) begin
    if (commit && wsel == SEL_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[awaddr_q[IDX_W+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Directed bench for axi4_lite_mem_slave with READ_LATENCY=3, WRITE_LATENCY=2.
module tb_axi4_lite_mem_slave;
  localparam int          ADDR_WIDTH = 32;
  localparam int          MEM_BYTES  = 131072;
  localparam logic [31:0] CONSOLE    = 32'h1000_0000;
  localparam logic [31:0] PASS       = 32'h2000_0000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       console_valid;
  logic [7:0] console_data;
  logic       tests_passed;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         consoleCount = 0;
  int         edgeMark;
  bit         seen;

  always #5 clk = ~clk;

  axi4_lite_mem_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  axi4_lite_mem_slave #(
    .ADDR_WIDTH(ADDR_WIDTH), .MEM_BYTES(MEM_BYTES),
    .READ_LATENCY(3), .WRITE_LATENCY(2)
  ) dut (
    .clk(clk), .resetn(resetn), .mem_axi(bus),
    .console_valid(console_valid), .console_data(console_data),
    .tests_passed(tests_passed)
  );

  // Edge counter and console strobe width monitor
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (console_valid) consoleCount = consoleCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = 3'b000;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = 4'h0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = 3'b000;
    bus.rready  = 1'b0;
  endtask

  // Full write; holds bready low for holdCycles after bvalid rises.
  task automatic axiWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int holdCycles, input logic [1:0] expResp);
    logic awPend, wPend, awGo, wGo;
    bit   got;
    @(negedge clk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    awPend = 1'b1; wPend = 1'b1;
    for (int t = 0; t < 40 && (awPend || wPend); t++) begin
      awGo = bus.awvalid && bus.awready;
      wGo  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (awGo) begin bus.awvalid = 1'b0; awPend = 1'b0; end
      if (wGo)  begin bus.wvalid  = 1'b0; wPend  = 1'b0; end
    end
    if (awPend || wPend) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus.bvalid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) checkOutput({tag, "_bvalid_timeout"}, 32'd0, 32'd1);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_bvalid"}, 32'(bus.bvalid), 32'd1);
      checkOutput({tag, "_hold_bresp"}, 32'(bus.bresp), 32'(expResp));
      checkOutput({tag, "_hold_awready"}, 32'(bus.awready), 32'd0);
      checkOutput({tag, "_hold_wready"}, 32'(bus.wready), 32'd0);
    end
    checkOutput({tag, "_bresp"}, 32'(bus.bresp), 32'(expResp));
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  // Full read; holds rready low for holdCycles after rvalid rises.
  task automatic axiRead(input string tag, input logic [31:0] addr, input int holdCycles,
                         input logic [31:0] expData, input logic [1:0] expResp);
    logic arPend, arGo;
    bit   got;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    arPend = 1'b1;
    for (int t = 0; t < 40 && arPend; t++) begin
      arGo = bus.arvalid && bus.arready;
      @(negedge clk);
      if (arGo) begin bus.arvalid = 1'b0; arPend = 1'b0; end
    end
    if (arPend) checkOutput({tag, "_ar_timeout"}, 32'd0, 32'd1);
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus.rvalid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) checkOutput({tag, "_rvalid_timeout"}, 32'd0, 32'd1);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_rvalid"}, 32'(bus.rvalid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, bus.rdata, expData);
      checkOutput({tag, "_hold_arready"}, 32'(bus.arready), 32'd0);
    end
    checkOutput({tag, "_rdata"}, bus.rdata, expData);
    checkOutput({tag, "_rresp"}, 32'(bus.rresp), 32'(expResp));
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_awready", 32'(bus.awready), 32'd0);
    checkOutput("rst_wready", 32'(bus.wready), 32'd0);
    checkOutput("rst_arready", 32'(bus.arready), 32'd0);
    checkOutput("rst_bvalid", 32'(bus.bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    checkOutput("rst_resps", {28'd0, bus.bresp, bus.rresp}, 32'd0);
    checkOutput("rst_console", {23'd0, console_valid, console_data}, 32'd0);
    checkOutput("rst_passed", 32'(tests_passed), 32'd0);

    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("post_rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'h7);

    // Full-word write then byte-lane 1 update
    axiWrite("wr_full", 32'h100, 32'hDEADBEEF, 4'b1111, 0, 2'b00);
    axiRead("rd_full", 32'h100, 0, 32'hDEADBEEF, 2'b00);
    axiWrite("wr_lane1", 32'h100, 32'h0000AA00, 4'b0010, 0, 2'b00);
    axiRead("rd_lane1", 32'h100, 0, 32'hDEADAAEF, 2'b00);

    // Read latency: handshake on edge N, rvalid first seen after edge N+4
    @(negedge clk);
    bus.araddr = 32'h100; bus.arvalid = 1'b1;
    checkOutput("lat_arready", 32'(bus.arready), 32'd1);
    @(negedge clk);
    edgeMark = cyc;
    bus.arvalid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus.rvalid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("rd_latency", seen ? 32'(cyc - edgeMark) : 32'hFFFF_FFFF, 32'd4);
    checkOutput("rd_latency_data", bus.rdata, 32'hDEADAAEF);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;

    // Write latency: W on edge M, AW on edge M+3, bvalid after edge M+6
    @(negedge clk);
    bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    edgeMark = cyc;
    bus.wvalid = 1'b0;
    checkOutput("w_held_wready", 32'(bus.wready), 32'd0);
    checkOutput("w_held_awready", 32'(bus.awready), 32'd1);
    repeat (2) @(negedge clk);
    bus.awaddr = 32'h104; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus.bvalid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("wr_latency", seen ? 32'(cyc - edgeMark) : 32'hFFFF_FFFF, 32'd6);
    checkOutput("wr_latency_bresp", 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;

    // Back-pressure on both response channels
    axiRead("rd_hold", 32'h104, 5, 32'hCAFEF00D, 2'b00);
    axiWrite("wr_hold", 32'h108, 32'h0BADCAFE, 4'hF, 5, 2'b00);
    axiRead("rd_108", 32'h108, 0, 32'h0BADCAFE, 2'b00);

    // Out-of-range accesses
    axiWrite("wr_word0", 32'h0, 32'h11223344, 4'hF, 0, 2'b00);
    axiRead("rd_word0", 32'h0, 0, 32'h11223344, 2'b00);
    axiRead("rd_oor", MEM_BYTES, 0, 32'd0, 2'b10);
    axiWrite("wr_oor", MEM_BYTES, 32'h55555555, 4'hF, 0, 2'b10);
    axiRead("rd_word0_after_oor", 32'h0, 0, 32'h11223344, 2'b00);

    // Console and pass MMIO
    consoleCount = 0;
    axiWrite("wr_console", CONSOLE, 32'h00000041, 4'hF, 0, 2'b00);
    repeat (3) @(negedge clk);
    checkOutput("console_pulse_cycles", 32'(consoleCount), 32'd1);
    checkOutput("console_data", 32'(console_data), 32'h41);
    axiRead("rd_console", CONSOLE, 0, 32'd0, 2'b00);
    axiWrite("wr_pass_bad", PASS, 32'd5, 4'hF, 0, 2'b00);
    checkOutput("passed_after_bad", 32'(tests_passed), 32'd0);
    axiRead("rd_pass_bad", PASS, 0, 32'd0, 2'b00);
    axiWrite("wr_pass_good", PASS, 32'd123456789, 4'hF, 0, 2'b00);
    checkOutput("passed_after_good", 32'(tests_passed), 32'd1);
    axiRead("rd_pass_good", PASS, 0, 32'd1, 2'b00);
    axiWrite("wr_pass_again", PASS, 32'd7, 4'hF, 0, 2'b00);
    checkOutput("passed_sticky", 32'(tests_passed), 32'd1);

    // Reset during write WAIT must discard the write
    consoleCount = 0;
    @(negedge clk);
    bus.awaddr = 32'h100; bus.awvalid = 1'b1;
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checkOutput("abort_wait_bvalid", 32'(bus.bvalid), 32'd0);
    resetn = 1'b0;
    #1;
    checkOutput("abort_rst_bvalid", 32'(bus.bvalid), 32'd0);
    checkOutput("abort_rst_awready", 32'(bus.awready), 32'd0);
    checkOutput("abort_rst_passed", 32'(tests_passed), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("abort_post_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'h7);
    repeat (5) @(negedge clk);
    checkOutput("abort_no_bvalid", 32'(bus.bvalid), 32'd0);
    checkOutput("abort_no_console", 32'(consoleCount), 32'd0);
    axiRead("rd_after_abort", 32'h100, 0, 32'hDEADAAEF, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
